// File: rtl/mod8_seq_checker.sv
// mod8_seq_checker: monitors a mod-8 counter stream for lock, sequence errors and wraps.
// Optional macro CHK_HOLD_OK_EN makes a repeated sample (stall) neutral.
module mod8_seq_checker #(
  parameter int LOCK_CYCLES = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        count_in,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count
);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  localparam logic [3:0] LC = 4'(LOCK_CYCLES);
  state_t state, state_n;
  logic [2:0] prev;
  logic [3:0] streak, streak_n;
  logic good, hold, err, wrap;
  logic [WRAP_W-1:0] wrap_base;
  logic [ERR_W-1:0] err_base;
  always_comb begin
    good = count_in == 3'(prev + 3'd1);
`ifdef CHK_HOLD_OK_EN
    hold = count_in == prev;
`else
    hold = 1'b0;
`endif
    state_n = state;
    streak_n = streak;
    err = 1'b0;
    wrap = 1'b0;
    case (state)
      IDLE: begin
        state_n = SYNC;
        streak_n = '0;
      end
      SYNC: begin
        streak_n = good ? streak + 4'd1 : hold ? streak : '0;
        state_n = good && streak_n == LC ? LOCKED : SYNC;
      end
      default: begin
        wrap = good && prev == 3'd7;
        err = !good && !hold;
        streak_n = err ? '0 : streak;
        state_n = err ? SYNC : LOCKED;
      end
    endcase
    // clear is applied first so a coincident error or wrap still counts
    wrap_base = clear ? '0 : wrap_count;
    err_base = clear ? '0 : err_count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prev <= '0;
      streak <= '0;
      err_pulse <= 1'b0;
      err_sticky <= 1'b0;
      wrap_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      prev <= count_in;
      streak <= streak_n;
      err_pulse <= err;
      err_sticky <= err || (err_sticky && !clear);
      wrap_count <= wrap_base + WRAP_W'(wrap);
      err_count <= err_base + ERR_W'(err && !(&err_base));
    end
  end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_mod8_seq_checker.sv
// tb_mod8_seq_checker: directed and random checks against a spec-level reference model.
module tb_mod8_seq_checker;
  localparam int LOCK = 4;
`ifdef CHK_HOLD_OK_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [2:0] count_in = '0;
  logic locked, err_pulse, err_sticky;
  logic [7:0] wrap_count, err_count;
  int n_chk = 0, n_fail = 0;
  bit m_first = 1'b1, m_lock = 1'b0, m_pulse = 1'b0, m_sticky = 1'b0;
  int m_prev = 0, m_streak = 0, m_wrap = 0, m_err = 0, cur = 0;

  mod8_seq_checker #(.LOCK_CYCLES(LOCK), .WRAP_W(8), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .wrap_count(wrap_count), .err_count(err_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input int c, input bit clr);
    bit good, hold, e, w;
    reset = r;
    count_in = 3'(c);
    clear = clr;
    cur = c;
    @(posedge clk);
    #1;
    e = 0;
    w = 0;
    if (r) begin
      m_first = 1; m_lock = 0; m_pulse = 0; m_sticky = 0;
      m_prev = 0; m_streak = 0; m_wrap = 0; m_err = 0;
    end else begin
      good = c == (m_prev + 1) % 8;
      hold = HOLD && c == m_prev;
      if (m_first) begin
        m_first = 0;
        m_streak = 0;
      end else if (!m_lock) begin
        if (good) m_streak++;
        else if (!hold) m_streak = 0;
        if (good && m_streak == LOCK) m_lock = 1;
      end else if (good) w = c == 0;
      else if (!hold) begin
        e = 1;
        m_lock = 0;
        m_streak = 0;
      end
      if (clr) begin m_wrap = 0; m_err = 0; m_sticky = 0; end
      if (w) m_wrap = (m_wrap + 1) % 256;
      if (e) begin m_sticky = 1; if (m_err < 255) m_err++; end
      m_pulse = e;
      m_prev = c;
    end
    chk("locked", int'(locked), int'(m_lock));
    chk("err_pulse", int'(err_pulse), int'(m_pulse));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    chk("wrap_count", int'(wrap_count), m_wrap);
    chk("err_count", int'(err_count), m_err);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, (cur + 1) % 8, 0);
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_locked", int'(locked), 0);
    for (int i = 0; i <= 3; i++) begin
      step(0, i, 0);
      chk("no_early_lock", int'(locked), 0);
    end
    step(0, 4, 0);
    chk("lock_after_4", int'(locked), 1);
    chk("no_wrap_yet", int'(wrap_count), 0);
    run(3 + 24);
    chk("three_wraps", int'(wrap_count), 3);
    chk("no_errors", int'(err_count), 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 2, 0);
    step(0, 3, 0);
    step(0, 5, 0);
    chk("inject_pulse", int'(err_pulse), 1);
    chk("inject_count", int'(err_count), 1);
    chk("inject_unlock", int'(locked), 0);
    step(0, 6, 0);
    chk("pulse_one_clk", int'(err_pulse), 0);
    run(2);
    step(0, 1, 0);
    chk("relock", int'(locked), 1);
    run(2);
    step(0, 3, 0);
    chk("hold_locked", int'(locked), HOLD ? 1 : 0);
    chk("hold_err", int'(err_count), HOLD ? 1 : 2);
    step(0, 3, 0);
    step(0, 0, 1);
    run(3);
    step(0, (cur + 1) % 8, 1);
    run(LOCK);
    run(7);
    step(0, 4, 1);
    for (int i = 0; i < 300; i++) begin
      run(LOCK);
      step(0, (cur + 3) % 8, 0);
    end
    chk("err_saturate", int'(err_count), 255);
    run(LOCK);
    step(0, (cur + 1) % 8, 1);
    chk("clear_err", int'(err_count), 0);
    chk("clear_sticky", int'(err_sticky), 0);
    chk("clear_keeps_lock", int'(locked), 1);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 15);
      int c = r < 2 ? int'($urandom_range(0, 7)) : r == 2 ? cur : (cur + 1) % 8;
      step(0, c, $urandom_range(0, 15) == 0);
    end
    run(LOCK + 1);
    step(0, (cur + 5) % 8, 0);
    run(LOCK + 1);
    step(1, 3, 0);
    chk("midreset_locked", int'(locked), 0);
    chk("midreset_sticky", int'(err_sticky), 0);
    chk("midreset_err", int'(err_count), 0);
    for (int i = 0; i <= LOCK; i++) step(0, i, 0);
    chk("lock_after_reset", int'(locked), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
